decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameters: none; register classes fixed at 32 INT + 32 FP, exe_unit one-hot 6 bits: [0]ALU [1]BJU [2]LSU [3]MDU [4]FPU [5]CSR.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 instN_valid_pre_i  in  1  (N=0,1) decoder slot N holds an instruction.
REQ-005 instN_rsK_valid_i / instN_rsK_i / instN_rsK_fp_i  in  1/5/1  (K=1,2,3) source used, address, 1=FP class.
REQ-006 instN_rd_type_i  in  2  00 none, 01 INT, 10 FP, 11 treated as none.
REQ-007 instN_rd_i  in  5  destination address.
REQ-008 instN_exe_unit_i  in  6  one-hot target unit.
REQ-009 wbM_valid_i / wbM_rd_type_i / wbM_rd_i  in  1/2/5  (M=0,1) writeback releases a destination.
REQ-010 mdu_done_i  in  1  non-pipelined MDU finished current op.
REQ-011 flush_i  in  1  pipeline flush from writeback.
REQ-012 stall_decoder_inst0_o / stall_decoder_inst1_o  out  1  hold decoder slot 0 / 1.
REQ-013 flush_decoder_inst0_o / flush_decoder_inst1_o  out  1  both equal flush_i combinationally.
REQ-014 stall_cycles_o  out  32  saturating count of cycles with slot 0 stalled.

Function
REQ-015 State: int_busy[31:0], fp_busy[31:0], MDU FSM {IDLE,BUSY}, stall_cycles counter; stall outputs combinational from state and current inputs (zero-latency).
REQ-016 Source hazard: rsK valid and busy bit of its class set (int x0 never busy).
REQ-017 WAW hazard: rd_type INT/FP and busy bit of rd set; INT rd=0 never hazards.
REQ-018 stall0 = inst0_valid_pre_i & (source hazard | WAW | (exe[3] & MDU BUSY) | (exe[5] & any busy bit set)).
REQ-019 stall1 = inst1_valid_pre_i & (stall0 | own source/WAW/MDU/CSR hazard | inst0 valid and rd matches any inst1 source of same class (rd≠INT x0) | inst0 valid and rd==inst1 rd same class | (exe0 & exe1 & 6'b111110)≠0 | inst0 valid and exe0[5]).
REQ-020 Hazards depending on inst0 apply only when inst0_valid_pre_i=1.
REQ-021 Issue: slot N issues when valid_pre & ~stallN & ~flush_i; slot 1 never issues without slot 0 unless slot 0 invalid.
REQ-022 Issue sets busy bit of rd (class per rd_type; INT x0 never set); MDU issue moves FSM IDLE->BUSY.
REQ-023 Writeback clears busy bit of wbM_rd in class wbM_rd_type; clear takes effect next cycle (no same-cycle bypass).
REQ-024 Same-cycle set and clear of same bit: set wins.
REQ-025 MDU BUSY->IDLE on mdu_done_i; MDU instruction presented same cycle as done still stalls.
REQ-026 flush_i: both stall outputs 0, no issue, all busy bits cleared, MDU FSM -> IDLE, wb clears ignored.
REQ-027 stall_cycles increments by 1 each cycle stall_decoder_inst0_o=1; holds at 32'hFFFF_FFFF.

Reset
REQ-028 rst=1: busy tables 0, MDU IDLE, stall_cycles_o 0; stall outputs 0 while rst=1; rst overrides flush_i and wb.
REQ-029 Reset asserted mid-MDU-op or with busy bits set returns to reset state next edge.

Verification
REQ-030 inst0 add rd=x5 INT issues; next cycle inst0 rs1=x5 -> stall0=1 until wb0 rd=x5 INT, stall0=0 cycle after wb.
REQ-031 Same cycle inst0 rd=x7 INT, inst1 rs2=x7 INT -> stall0=0, stall1=1; inst1 rs2=x7 FP -> stall1=0.
REQ-032 Both slots LSU -> stall1=1; both ALU no deps -> both issue, stall1=0.
REQ-033 MDU issue, second MDU next cycle -> stalled; mdu_done_i pulse -> issues cycle after.
REQ-034 Busy x3,x4,f2 set, flush_i=1 -> flush outputs 1, stalls 0, next cycle all busy cleared.
REQ-035 Preload stall_cycles near max (force 32'hFFFF_FFFE), hold stall two cycles -> reads 32'hFFFF_FFFF and stays.

Source files
------------

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: dual-issue decode hazard scoreboard with INT/FP busy tables and MDU occupancy
module decode_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst0_valid_pre_i,
  input  logic        inst0_rs1_valid_i,
  input  logic [4:0]  inst0_rs1_i,
  input  logic        inst0_rs1_fp_i,
  input  logic        inst0_rs2_valid_i,
  input  logic [4:0]  inst0_rs2_i,
  input  logic        inst0_rs2_fp_i,
  input  logic        inst0_rs3_valid_i,
  input  logic [4:0]  inst0_rs3_i,
  input  logic        inst0_rs3_fp_i,
  input  logic [1:0]  inst0_rd_type_i,
  input  logic [4:0]  inst0_rd_i,
  input  logic [5:0]  inst0_exe_unit_i,
  input  logic        inst1_valid_pre_i,
  input  logic        inst1_rs1_valid_i,
  input  logic [4:0]  inst1_rs1_i,
  input  logic        inst1_rs1_fp_i,
  input  logic        inst1_rs2_valid_i,
  input  logic [4:0]  inst1_rs2_i,
  input  logic        inst1_rs2_fp_i,
  input  logic        inst1_rs3_valid_i,
  input  logic [4:0]  inst1_rs3_i,
  input  logic        inst1_rs3_fp_i,
  input  logic [1:0]  inst1_rd_type_i,
  input  logic [4:0]  inst1_rd_i,
  input  logic [5:0]  inst1_exe_unit_i,
  input  logic        wb0_valid_i,
  input  logic [1:0]  wb0_rd_type_i,
  input  logic [4:0]  wb0_rd_i,
  input  logic        wb1_valid_i,
  input  logic [1:0]  wb1_rd_type_i,
  input  logic [4:0]  wb1_rd_i,
  input  logic        mdu_done_i,
  input  logic        flush_i,
  output logic        stall_decoder_inst0_o,
  output logic        stall_decoder_inst1_o,
  output logic        flush_decoder_inst0_o,
  output logic        flush_decoder_inst1_o,
  output logic [31:0] stall_cycles_o
);
  typedef enum logic {IDLE, BUSY} mdu_state_t;
  mdu_state_t r_mdu, w_mdu_nxt;
  logic [31:0] r_int_busy, r_fp_busy, r_stall_cycles;
  logic [31:0] w_set_int, w_set_fp, w_clr_int, w_clr_fp;
  logic [1:0] w_v, w_wint, w_wfp, w_own, w_iss, w_wbv;
  logic [1:0][2:0] w_rsv, w_rsfp, w_src;
  logic [1:0][2:0][4:0] w_rs;
  logic [1:0][1:0] w_rdt, w_wbt;
  logic [1:0][4:0] w_rd, w_wbrd;
  logic [1:0][5:0] w_exe;
  logic [2:0] w_raw;
  logic w_gate, w_pair, w_stall0, w_stall1, w_mdu_iss;

  assign w_v    = {inst1_valid_pre_i, inst0_valid_pre_i};
  assign w_rsv  = {inst1_rs3_valid_i, inst1_rs2_valid_i, inst1_rs1_valid_i,
                   inst0_rs3_valid_i, inst0_rs2_valid_i, inst0_rs1_valid_i};
  assign w_rs   = {inst1_rs3_i, inst1_rs2_i, inst1_rs1_i, inst0_rs3_i, inst0_rs2_i, inst0_rs1_i};
  assign w_rsfp = {inst1_rs3_fp_i, inst1_rs2_fp_i, inst1_rs1_fp_i,
                   inst0_rs3_fp_i, inst0_rs2_fp_i, inst0_rs1_fp_i};
  assign w_rdt  = {inst1_rd_type_i, inst0_rd_type_i};
  assign w_rd   = {inst1_rd_i, inst0_rd_i};
  assign w_exe  = {inst1_exe_unit_i, inst0_exe_unit_i};
  assign w_wbv  = {wb1_valid_i, wb0_valid_i};
  assign w_wbt  = {wb1_rd_type_i, wb0_rd_type_i};
  assign w_wbrd = {wb1_rd_i, wb0_rd_i};

  for (genvar n = 0; n < 2; n++) begin : g_slot
    assign w_wint[n] = w_rdt[n] == 2'b01 && w_rd[n] != 5'd0;
    assign w_wfp[n]  = w_rdt[n] == 2'b10;
    for (genvar k = 0; k < 3; k++) begin : g_src
      assign w_src[n][k] = w_rsv[n][k] && (w_rsfp[n][k] ? r_fp_busy[w_rs[n][k]]
                                                          : r_int_busy[w_rs[n][k]] && w_rs[n][k] != 5'd0);
    end
    assign w_own[n] = |w_src[n] || (w_wint[n] && r_int_busy[w_rd[n]]) || (w_wfp[n] && r_fp_busy[w_rd[n]]) ||
                      (w_exe[n][3] && r_mdu == BUSY) || (w_exe[n][5] && |{r_int_busy, r_fp_busy});
  end

  for (genvar k = 0; k < 3; k++) begin : g_raw
    assign w_raw[k] = w_rsv[1][k] && w_rs[1][k] == w_rd[0] && (w_rsfp[1][k] ? w_wfp[0] : w_wint[0]);
  end

  assign w_gate   = !rst && !flush_i;
  assign w_pair   = w_rd[0] == w_rd[1] && ((w_wint[0] && w_wint[1]) || (w_wfp[0] && w_wfp[1]));
  assign w_stall0 = w_gate && w_v[0] && w_own[0];
  assign w_stall1 = w_gate && w_v[1] && (w_stall0 || w_own[1] ||
                    (w_v[0] && (|w_raw || w_pair || |(w_exe[0] & w_exe[1] & 6'b111110) || w_exe[0][5])));
  assign w_iss     = {w_gate && w_v[1] && !w_stall1, w_gate && w_v[0] && !w_stall0};
  assign w_mdu_iss = |(w_iss & {w_exe[1][3], w_exe[0][3]});

  always_comb begin
    w_set_int = '0;
    w_set_fp  = '0;
    w_clr_int = '0;
    w_clr_fp  = '0;
    for (int i = 0; i < 2; i++) begin
      if (w_iss[i] && w_wint[i]) w_set_int[w_rd[i]] = 1'b1;
      if (w_iss[i] && w_wfp[i]) w_set_fp[w_rd[i]] = 1'b1;
      if (w_wbv[i] && w_wbt[i] == 2'b01) w_clr_int[w_wbrd[i]] = 1'b1;
      if (w_wbv[i] && w_wbt[i] == 2'b10) w_clr_fp[w_wbrd[i]] = 1'b1;
    end
  end

  always_comb begin
    w_mdu_nxt = r_mdu;
    if (flush_i) w_mdu_nxt = IDLE;
    else if (r_mdu == BUSY) w_mdu_nxt = mdu_done_i ? IDLE : BUSY;
    else w_mdu_nxt = w_mdu_iss ? BUSY : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mdu          <= IDLE;
      r_int_busy     <= '0;
      r_fp_busy      <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_mdu      <= w_mdu_nxt;
      r_int_busy <= flush_i ? '0 : (r_int_busy & ~w_clr_int) | w_set_int;
      r_fp_busy  <= flush_i ? '0 : (r_fp_busy & ~w_clr_fp) | w_set_fp;
      if (w_stall0 && r_stall_cycles != 32'hFFFF_FFFF) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_decoder_inst0_o = w_stall0;
  assign stall_decoder_inst1_o = w_stall1;
  assign flush_decoder_inst0_o = flush_i;
  assign flush_decoder_inst1_o = flush_i;
  assign stall_cycles_o        = r_stall_cycles;
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: scoreboard bench comparing the decode scoreboard against a register-set reference model
module tb_decode_scoreboard;
  typedef struct packed {
    logic            valid;
    logic [2:0]      rsv;
    logic [2:0][4:0] rs;
    logic [2:0]      rsfp;
    logic [1:0]      rdt;
    logic [4:0]      rd;
    logic [5:0]      exe;
  } inst_t;
  typedef struct packed {
    logic        s0;
    logic        s1;
    logic        f;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [5:0] ALU = 6'b000001, LSU = 6'b000100, MDU = 6'b001000, CSR = 6'b100000;

  logic clk, rst, flush, done, fin;
  logic [1:0] wbv;
  logic [1:0][1:0] wbt;
  logic [1:0][4:0] wbrd;
  inst_t i0, i1;
  logic s0_o, s1_o, f0_o, f1_o;
  logic [31:0] cnt_o;

  bit [63:0] bz;
  bit mdu;
  logic [31:0] cnt;
  exp_t q[$];
  exp_t me;
  int nchk, nfail;

  decode_scoreboard dut (
    .clk(clk), .rst(rst),
    .inst0_valid_pre_i(i0.valid),
    .inst0_rs1_valid_i(i0.rsv[0]), .inst0_rs1_i(i0.rs[0]), .inst0_rs1_fp_i(i0.rsfp[0]),
    .inst0_rs2_valid_i(i0.rsv[1]), .inst0_rs2_i(i0.rs[1]), .inst0_rs2_fp_i(i0.rsfp[1]),
    .inst0_rs3_valid_i(i0.rsv[2]), .inst0_rs3_i(i0.rs[2]), .inst0_rs3_fp_i(i0.rsfp[2]),
    .inst0_rd_type_i(i0.rdt), .inst0_rd_i(i0.rd), .inst0_exe_unit_i(i0.exe),
    .inst1_valid_pre_i(i1.valid),
    .inst1_rs1_valid_i(i1.rsv[0]), .inst1_rs1_i(i1.rs[0]), .inst1_rs1_fp_i(i1.rsfp[0]),
    .inst1_rs2_valid_i(i1.rsv[1]), .inst1_rs2_i(i1.rs[1]), .inst1_rs2_fp_i(i1.rsfp[1]),
    .inst1_rs3_valid_i(i1.rsv[2]), .inst1_rs3_i(i1.rs[2]), .inst1_rs3_fp_i(i1.rsfp[2]),
    .inst1_rd_type_i(i1.rdt), .inst1_rd_i(i1.rd), .inst1_exe_unit_i(i1.exe),
    .wb0_valid_i(wbv[0]), .wb0_rd_type_i(wbt[0]), .wb0_rd_i(wbrd[0]),
    .wb1_valid_i(wbv[1]), .wb1_rd_type_i(wbt[1]), .wb1_rd_i(wbrd[1]),
    .mdu_done_i(done), .flush_i(flush),
    .stall_decoder_inst0_o(s0_o), .stall_decoder_inst1_o(s1_o),
    .flush_decoder_inst0_o(f0_o), .flush_decoder_inst1_o(f1_o),
    .stall_cycles_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registers are numbered 0..31 INT and 32..63 FP; -1 means no register (incl. INT x0)
  function automatic int dst(inst_t x);
    if (x.rdt == 2'b01 && x.rd != 5'd0) return int'(x.rd);
    if (x.rdt == 2'b10) return 32 + int'(x.rd);
    return -1;
  endfunction

  function automatic int src(inst_t x, int k);
    if (!x.rsv[k]) return -1;
    if (x.rsfp[k]) return 32 + int'(x.rs[k]);
    return x.rs[k] == 5'd0 ? -1 : int'(x.rs[k]);
  endfunction

  function automatic bit own(inst_t x);
    bit h = 0;
    for (int k = 0; k < 3; k++) if (src(x, k) >= 0 && bz[src(x, k)]) h = 1;
    if (dst(x) >= 0 && bz[dst(x)]) h = 1;
    if (x.exe[3] && mdu) h = 1;
    if (x.exe[5] && bz != 0) h = 1;
    return h;
  endfunction

  function automatic bit pred_s0();
    return !rst && !flush && i0.valid && own(i0);
  endfunction

  function automatic bit pred_s1();
    bit c = 0;
    int d0 = dst(i0);
    if (i0.valid) begin
      for (int k = 0; k < 3; k++) if (d0 >= 0 && d0 == src(i1, k)) c = 1;
      if (d0 >= 0 && d0 == dst(i1)) c = 1;
      if ((i0.exe & i1.exe & 6'b111110) != 0) c = 1;
      if (i0.exe[5]) c = 1;
    end
    return !rst && !flush && i1.valid && (pred_s0() || own(i1) || c);
  endfunction

  task automatic update(bit s0, bit s1);
    if (rst) begin
      bz = 0; mdu = 0; cnt = 0;
    end else if (flush) begin
      bz = 0; mdu = 0;
    end else begin
      if (s0 && cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
      for (int m = 0; m < 2; m++) if (wbv[m]) begin
        if (wbt[m] == 2'b01) bz[wbrd[m]] = 0;
        else if (wbt[m] == 2'b10) bz[32 + int'(wbrd[m])] = 0;
      end
      if (mdu && done) mdu = 0;
      if (i0.valid && !s0) begin
        if (dst(i0) >= 0) bz[dst(i0)] = 1;
        if (i0.exe[3]) mdu = 1;
      end
      if (i1.valid && !s1) begin
        if (dst(i1) >= 0) bz[dst(i1)] = 1;
        if (i1.exe[3]) mdu = 1;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    bit s0 = pred_s0();
    bit s1 = pred_s1();
    e.s0 = s0; e.s1 = s1; e.f = flush; e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    update(s0, s1);
    #1;
  endtask

  function automatic inst_t mk(logic [5:0] exe, logic [1:0] rdt, logic [4:0] rd);
    inst_t x = '0;
    x.valid = 1'b1; x.exe = exe; x.rdt = rdt; x.rd = rd;
    return x;
  endfunction

  function automatic inst_t rnd();
    inst_t x;
    x.valid = $urandom_range(0, 7) != 0;
    x.rsv = 3'($urandom);
    for (int k = 0; k < 3; k++) x.rs[k] = 5'($urandom_range(0, 7));
    x.rsfp = 3'($urandom);
    x.rdt = 2'($urandom);
    x.rd = 5'($urandom_range(0, 7));
    x.exe = 6'(1 << $urandom_range(0, 5));
    return x;
  endfunction

  task automatic idle();
    i0 = '0; i1 = '0; wbv = '0; wbt = '0; wbrd = '0; done = 0; flush = 0; rst = 0;
  endtask

  task automatic do_flush();
    idle(); flush = 1; tick(); flush = 0;
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("stall0", 32'(s0_o), 32'(me.s0));
      chk("stall1", 32'(s1_o), 32'(me.s1));
      chk("flush0", 32'(f0_o), 32'(me.f));
      chk("flush1", 32'(f1_o), 32'(me.f));
      chk("stall_cycles", cnt_o, me.cnt);
    end else if (fin) begin
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
    end
  end

  initial begin
    fin = 0; bz = 0; mdu = 0; cnt = 0;
    idle(); rst = 1;
    @(posedge clk); #1;
    tick(); tick();
    idle();
    // RAW on x5 held until writeback, released the cycle after
    i0 = mk(ALU, 2'b01, 5'd5); tick();
    i0 = mk(ALU, 2'b01, 5'd6); i0.rsv[0] = 1; i0.rs[0] = 5'd5; tick(); tick();
    wbv[0] = 1; wbt[0] = 2'b01; wbrd[0] = 5'd5; tick();
    wbv = '0; tick(); tick();
    do_flush();
    // intra-pair RAW, INT vs FP class
    i0 = mk(ALU, 2'b01, 5'd7); i1 = mk(ALU, 2'b01, 5'd8); i1.rsv[1] = 1; i1.rs[1] = 5'd7; tick();
    do_flush();
    i0 = mk(ALU, 2'b01, 5'd7); i1 = mk(ALU, 2'b01, 5'd8); i1.rsv[1] = 1; i1.rs[1] = 5'd7; i1.rsfp[1] = 1; tick();
    do_flush();
    // structural: both LSU, then both ALU
    i0 = mk(LSU, 2'b01, 5'd1); i1 = mk(LSU, 2'b01, 5'd2); tick();
    do_flush();
    i0 = mk(ALU, 2'b01, 5'd1); i1 = mk(ALU, 2'b01, 5'd2); tick();
    do_flush();
    // MDU occupancy
    i0 = mk(MDU, 2'b01, 5'd9); tick();
    i0 = mk(MDU, 2'b01, 5'd10); tick(); tick();
    done = 1; tick();
    done = 0; tick();
    idle(); i0 = mk(CSR, 2'b00, 5'd0); tick();
    do_flush();
    // flush clears x3, x4, f2
    i0 = mk(ALU, 2'b01, 5'd3); i1 = mk(ALU, 2'b01, 5'd4); tick();
    i0 = mk(ALU, 2'b10, 5'd2); i1 = '0; tick();
    i0 = mk(ALU, 2'b01, 5'd11); i0.rsv = 3'b111; i0.rs = {5'd2, 5'd4, 5'd3}; i0.rsfp = 3'b100;
    flush = 1; wbv[0] = 1; wbt[0] = 2'b01; wbrd[0] = 5'd3; tick();
    flush = 0; wbv = '0; tick();
    do_flush();
    // reset mid-MDU op with busy bits set
    i0 = mk(MDU, 2'b10, 5'd4); tick();
    i0 = mk(MDU, 2'b10, 5'd5); i0.rsv[0] = 1; i0.rs[0] = 5'd4; i0.rsfp[0] = 1; tick();
    rst = 1; flush = 1; tick();
    rst = 0; flush = 0; tick();
    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      i0 = rnd(); i1 = rnd();
      rst = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 49) == 0;
      done = $urandom_range(0, 3) == 0;
      for (int m = 0; m < 2; m++) begin
        wbv[m] = $urandom_range(0, 1) != 0;
        wbt[m] = 2'($urandom_range(1, 2));
        wbrd[m] = 5'($urandom_range(0, 7));
      end
      tick();
    end
    do_flush();
    // counter saturation from a preloaded near-max value
    i0 = mk(ALU, 2'b01, 5'd12); tick();
    i0 = mk(ALU, 2'b01, 5'd13); i0.rsv[0] = 1; i0.rs[0] = 5'd12;
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    cnt = 32'hFFFF_FFFE;
    fork
      begin @(negedge clk); #1; release dut.r_stall_cycles; end
    join_none
    tick(); tick(); tick(); tick();
    idle(); tick();
    fin = 1;
  end
endmodule
